// File: rtl/div_pkg.sv
// Shared definitions for the iterative divider.
//   state_t  : FSM encoding (IDLE=0, CALC=1, FIX=2, DONE=3)
//   ITER     : iterations for the default build (DEF_WIDTH/DEF_STEPS)
//   neg_if   : conditional two's-complement negate, NEG_W bits wide;
//              callers zero-extend in and truncate out, so WIDTH <= NEG_W.
package div_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    FIX  = 2'd2,
    DONE = 2'd3
  } state_t;

  localparam int DEF_WIDTH = 32;
  localparam int DEF_STEPS = 1;
  localparam int ITER      = DEF_WIDTH / DEF_STEPS;
  localparam int NEG_W     = 64;

  // Low WIDTH bits of the negated zero-extended value equal the WIDTH-bit
  // two's-complement negate, so one wide function serves every width.
  function automatic logic [NEG_W-1:0] neg_if(input logic [NEG_W-1:0] value,
                                               input logic             cond);
    return cond ? (~value + NEG_W'(1)) : value;
  endfunction

endpackage

// File: rtl/div_iter_if.sv
// Request/response bundle of the divider.
//   request : i_valid, o_ready, i_signed, i_a, i_b
//   response: o_valid, i_ready, o_quo, o_rem, o_dbz, o_ovf
// Signal names are as seen from the divider; slave = divider side,
// master = requester side.
interface div_iter_if #(
  parameter int WIDTH = 32
) ();

  logic             i_valid;
  logic             o_ready;
  logic             i_signed;
  logic [WIDTH-1:0] i_a;
  logic [WIDTH-1:0] i_b;
  logic             o_valid;
  logic             i_ready;
  logic [WIDTH-1:0] o_quo;
  logic [WIDTH-1:0] o_rem;
  logic             o_dbz;
  logic             o_ovf;

  modport slave (
    input  i_valid, i_signed, i_a, i_b, i_ready,
    output o_ready, o_valid, o_quo, o_rem, o_dbz, o_ovf
  );

  modport master (
    output i_valid, i_signed, i_a, i_b, i_ready,
    input  o_ready, o_valid, o_quo, o_rem, o_dbz, o_ovf
  );

endinterface

// File: rtl/div_step.sv
// One combinational restoring-division step.
//   acc      : partial remainder (WIDTH+1 bits, always < dvs on entry)
//   quo      : dividend bits still to shift in / quotient bits so far
//   dvs      : divisor magnitude
//   acc_next : partial remainder after shift and conditional subtract
//   quo_next : quo shifted left, LSB = 1 when the subtract happened
module div_step #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH:0]   acc,
  input  logic [WIDTH-1:0] quo,
  input  logic [WIDTH-1:0] dvs,
  output logic [WIDTH:0]   acc_next,
  output logic [WIDTH-1:0] quo_next
);

  logic [WIDTH+1:0] sh;
  logic [WIDTH+1:0] diff;
  logic             ge;

  // One spare bit so the borrow of the trial subtract lands in diff's MSB.
  assign sh       = {acc, quo[WIDTH-1]};
  assign diff     = sh - {2'b00, dvs};
  assign ge       = ~diff[WIDTH+1];
  assign acc_next = ge ? diff[WIDTH:0] : sh[WIDTH:0];
  assign quo_next = {quo[WIDTH-2:0], ge};

endmodule

// File: rtl/div_iter.sv
// Iterative restoring divider, RISC-V DIV/DIVU/REM/REMU semantics.
//   i_clk, i_rst : clock, synchronous active-high reset
//   bus          : div_iter_if.slave (request/response handshakes)
// Parameters: WIDTH (even, >= 4, <= 64, must match the interface width),
//             STEPS (power of two dividing WIDTH) quotient bits per clock.
// Latency from accept edge to o_valid: WIDTH/STEPS+2 normally, 1 for the
// divide-by-zero and signed-overflow fast paths.
module div_iter
  import div_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int STEPS = 1
) (
  input  logic       i_clk,
  input  logic       i_rst,
  div_iter_if.slave  bus
);

  localparam int NITER = WIDTH / STEPS;
  localparam int CW    = $clog2(NITER) + 1;
  localparam logic [WIDTH-1:0] MIN_VAL = {1'b1, {(WIDTH-1){1'b0}}};

  state_t           state, state_nxt;
  logic [CW-1:0]    cnt;
  logic [WIDTH:0]   acc;
  logic [WIDTH-1:0] quo;
  logic [WIDTH-1:0] dvs;
  logic             sgn, a_neg, b_neg;
  logic [WIDTH-1:0] res_quo, res_rem;
  logic             res_dbz, res_ovf;

  logic             is_dbz, is_ovf, last_iter;
  logic [WIDTH-1:0] a_abs, b_abs;

  assign is_dbz    = (bus.i_b == '0);
  assign is_ovf    = bus.i_signed & (bus.i_a == MIN_VAL) & (&bus.i_b);
  assign last_iter = (cnt == CW'(NITER - 1));
  assign a_abs     = WIDTH'(neg_if(NEG_W'(bus.i_a), bus.i_signed & bus.i_a[WIDTH-1]));
  assign b_abs     = WIDTH'(neg_if(NEG_W'(bus.i_b), bus.i_signed & bus.i_b[WIDTH-1]));

  // STEPS restoring steps chained within one clock.
  logic [WIDTH:0]   acc_c [STEPS+1];
  logic [WIDTH-1:0] quo_c [STEPS+1];
  assign acc_c[0] = acc;
  assign quo_c[0] = quo;

  for (genvar g = 0; g < STEPS; g++) begin : g_step
    div_step #(.WIDTH(WIDTH)) u_step (
      .acc      (acc_c[g]),
      .quo      (quo_c[g]),
      .dvs      (dvs),
      .acc_next (acc_c[g+1]),
      .quo_next (quo_c[g+1])
    );
  end

  // FSM state register
  always_ff @(posedge i_clk) begin
    if (i_rst) state <= IDLE;
    else       state <= state_nxt;
  end

  // FSM next state and handshake outputs; reset forces handshakes low.
  always_comb begin
    state_nxt   = state;
    bus.o_ready = 1'b0;
    bus.o_valid = 1'b0;
    case (state)
      IDLE: begin
        bus.o_ready = ~i_rst;
        if (bus.i_valid) state_nxt = (is_dbz | is_ovf) ? DONE : CALC;
      end
      CALC: if (last_iter) state_nxt = FIX;
      FIX:  state_nxt = DONE;
      DONE: begin
        bus.o_valid = ~i_rst;
        if (bus.i_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Datapath
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      cnt     <= '0;
      acc     <= '0;
      quo     <= '0;
      dvs     <= '0;
      sgn     <= 1'b0;
      a_neg   <= 1'b0;
      b_neg   <= 1'b0;
      res_quo <= '0;
      res_rem <= '0;
      res_dbz <= 1'b0;
      res_ovf <= 1'b0;
    end else begin
      case (state)
        IDLE: if (bus.i_valid) begin
          sgn   <= bus.i_signed;
          a_neg <= bus.i_signed & bus.i_a[WIDTH-1];
          b_neg <= bus.i_signed & bus.i_b[WIDTH-1];
          dvs   <= b_abs;
          quo   <= a_abs;
          acc   <= '0;
          cnt   <= '0;
          // Fast-path results go straight to the output registers.
          if (is_dbz) begin
            res_quo <= '1;
            res_rem <= bus.i_a;
            res_dbz <= 1'b1;
            res_ovf <= 1'b0;
          end else if (is_ovf) begin
            res_quo <= MIN_VAL;
            res_rem <= '0;
            res_dbz <= 1'b0;
            res_ovf <= 1'b1;
          end
        end
        CALC: begin
          acc <= acc_c[STEPS];
          quo <= quo_c[STEPS];
          cnt <= cnt + CW'(1);
        end
        FIX: begin
          // Truncating quotient; remainder takes the dividend's sign.
          res_quo <= WIDTH'(neg_if(NEG_W'(quo), sgn & (a_neg ^ b_neg)));
          res_rem <= WIDTH'(neg_if(NEG_W'(acc[WIDTH-1:0]), sgn & a_neg));
          res_dbz <= 1'b0;
          res_ovf <= 1'b0;
        end
        default: ;
      endcase
    end
  end

  assign bus.o_quo = i_rst ? '0 : res_quo;
  assign bus.o_rem = i_rst ? '0 : res_rem;
  assign bus.o_dbz = i_rst ? 1'b0 : res_dbz;
  assign bus.o_ovf = i_rst ? 1'b0 : res_ovf;

endmodule

// File: tb/tb_div_iter.sv
// Directed bench for div_iter: a STEPS=1 and a STEPS=4 instance, both WIDTH=32.
module tb_div_iter;

  logic i_clk = 1'b0;
  logic i_rst = 1'b1;
  always #5 i_clk = ~i_clk;

  div_iter_if #(.WIDTH(32)) b1 ();
  div_iter_if #(.WIDTH(32)) b4 ();

  div_iter #(.WIDTH(32), .STEPS(1)) dut  (.i_clk(i_clk), .i_rst(i_rst), .bus(b1.slave));
  div_iter #(.WIDTH(32), .STEPS(4)) dut4 (.i_clk(i_clk), .i_rst(i_rst), .bus(b4.slave));

  int n_cmp = 0;
  int n_bad = 0;

  // Issue one request on the selected DUT (caller is #1 after an edge with the
  // DUT idle), wait for the result, capture it and retire it.
  // lat = 1 means o_valid was visible right after the accept edge.
  task automatic do_op(input bit sel, input logic s, input logic [31:0] a, input logic [31:0] b,
                       output logic [31:0] q, output logic [31:0] r,
                       output logic dbz, output logic ovf, output int lat);
    if (sel) begin b4.i_valid = 1'b1; b4.i_signed = s; b4.i_a = a; b4.i_b = b; end
    else     begin b1.i_valid = 1'b1; b1.i_signed = s; b1.i_a = a; b1.i_b = b; end
    @(posedge i_clk); #1;
    b1.i_valid = 1'b0; b4.i_valid = 1'b0;
    lat = 1;
    while (!(sel ? b4.o_valid : b1.o_valid) && lat < 200) begin
      @(posedge i_clk); #1;
      lat++;
    end
    q   = sel ? b4.o_quo : b1.o_quo;
    r   = sel ? b4.o_rem : b1.o_rem;
    dbz = sel ? b4.o_dbz : b1.o_dbz;
    ovf = sel ? b4.o_ovf : b1.o_ovf;
    if (sel) b4.i_ready = 1'b1; else b1.i_ready = 1'b1;
    @(posedge i_clk); #1;
    b1.i_ready = 1'b0; b4.i_ready = 1'b0;
  endtask

  task automatic test_reset();
    i_rst = 1'b1;
    repeat (2) @(posedge i_clk);
    #1;
    n_cmp++; if (b1.o_ready !== 1'b0) begin n_bad++; $display("FAIL rst_ready: got %b want 0", b1.o_ready); end
    n_cmp++; if (b1.o_valid !== 1'b0) begin n_bad++; $display("FAIL rst_valid: got %b want 0", b1.o_valid); end
    n_cmp++; if ({b1.o_quo, b1.o_rem} !== 64'd0) begin n_bad++; $display("FAIL rst_data: got %h %h want 0 0", b1.o_quo, b1.o_rem); end
    n_cmp++; if ({b1.o_dbz, b1.o_ovf, b4.o_ready, b4.o_valid} !== 4'b0) begin n_bad++; $display("FAIL rst_flags: got %b want 0000", {b1.o_dbz, b1.o_ovf, b4.o_ready, b4.o_valid}); end
    i_rst = 1'b0;
    @(posedge i_clk); #1;
    n_cmp++; if (b1.o_ready !== 1'b1) begin n_bad++; $display("FAIL post_rst_ready: got %b want 1", b1.o_ready); end
    n_cmp++; if (b4.o_ready !== 1'b1) begin n_bad++; $display("FAIL post_rst_ready4: got %b want 1", b4.o_ready); end
  endtask

  task automatic test_unsigned();
    logic [31:0] q, r; logic dbz, ovf; int lat;
    do_op(1'b0, 1'b0, 32'd100, 32'd7, q, r, dbz, ovf, lat);
    n_cmp++; if (q !== 32'd14) begin n_bad++; $display("FAIL u100_7_quo: got %h want %h", q, 32'd14); end
    n_cmp++; if (r !== 32'd2) begin n_bad++; $display("FAIL u100_7_rem: got %h want %h", r, 32'd2); end
    n_cmp++; if (lat !== 34) begin n_bad++; $display("FAIL u100_7_lat: got %0d want 34", lat); end
    n_cmp++; if ({dbz, ovf} !== 2'b00) begin n_bad++; $display("FAIL u100_7_flags: got %b want 00", {dbz, ovf}); end
  endtask

  task automatic test_signed();
    logic [31:0] q, r; logic dbz, ovf; int lat;
    do_op(1'b0, 1'b1, 32'hFFFF_FFF9, 32'd2, q, r, dbz, ovf, lat);
    n_cmp++; if (q !== 32'hFFFF_FFFD) begin n_bad++; $display("FAIL sm7_2_quo: got %h want FFFFFFFD", q); end
    n_cmp++; if (r !== 32'hFFFF_FFFF) begin n_bad++; $display("FAIL sm7_2_rem: got %h want FFFFFFFF", r); end
    do_op(1'b0, 1'b1, 32'd7, 32'hFFFF_FFFE, q, r, dbz, ovf, lat);
    n_cmp++; if (q !== 32'hFFFF_FFFD) begin n_bad++; $display("FAIL s7_m2_quo: got %h want FFFFFFFD", q); end
    n_cmp++; if (r !== 32'd1) begin n_bad++; $display("FAIL s7_m2_rem: got %h want 1", r); end
    n_cmp++; if (lat !== 34) begin n_bad++; $display("FAIL s7_m2_lat: got %0d want 34", lat); end
  endtask

  task automatic test_dbz();
    logic [31:0] q, r; logic dbz, ovf; int lat;
    for (int s = 0; s < 2; s++) begin
      do_op(1'b0, s[0], 32'h1234_5678, 32'd0, q, r, dbz, ovf, lat);
      n_cmp++; if (q !== 32'hFFFF_FFFF) begin n_bad++; $display("FAIL dbz%0d_quo: got %h want FFFFFFFF", s, q); end
      n_cmp++; if (r !== 32'h1234_5678) begin n_bad++; $display("FAIL dbz%0d_rem: got %h want 12345678", s, r); end
      n_cmp++; if ({dbz, ovf} !== 2'b10) begin n_bad++; $display("FAIL dbz%0d_flags: got %b want 10", s, {dbz, ovf}); end
      n_cmp++; if (lat !== 1) begin n_bad++; $display("FAIL dbz%0d_lat: got %0d want 1", s, lat); end
    end
  endtask

  task automatic test_overflow();
    logic [31:0] q, r; logic dbz, ovf; int lat;
    do_op(1'b0, 1'b1, 32'h8000_0000, 32'hFFFF_FFFF, q, r, dbz, ovf, lat);
    n_cmp++; if (q !== 32'h8000_0000) begin n_bad++; $display("FAIL ovf_quo: got %h want 80000000", q); end
    n_cmp++; if (r !== 32'd0) begin n_bad++; $display("FAIL ovf_rem: got %h want 0", r); end
    n_cmp++; if ({dbz, ovf} !== 2'b01) begin n_bad++; $display("FAIL ovf_flags: got %b want 01", {dbz, ovf}); end
    n_cmp++; if (lat !== 1) begin n_bad++; $display("FAIL ovf_lat: got %0d want 1", lat); end
    do_op(1'b0, 1'b0, 32'h8000_0000, 32'hFFFF_FFFF, q, r, dbz, ovf, lat);
    n_cmp++; if (q !== 32'd0) begin n_bad++; $display("FAIL uovf_quo: got %h want 0", q); end
    n_cmp++; if (r !== 32'h8000_0000) begin n_bad++; $display("FAIL uovf_rem: got %h want 80000000", r); end
    n_cmp++; if ({dbz, ovf} !== 2'b00) begin n_bad++; $display("FAIL uovf_flags: got %b want 00", {dbz, ovf}); end
    n_cmp++; if (lat !== 34) begin n_bad++; $display("FAIL uovf_lat: got %0d want 34", lat); end
  endtask

  task automatic test_backpressure();
    int wait_cyc = 0;
    int stray = 0;
    b1.i_valid = 1'b1; b1.i_signed = 1'b0; b1.i_a = 32'd100; b1.i_b = 32'd7;
    @(posedge i_clk); #1;
    b1.i_valid = 1'b0;
    while (!b1.o_valid && wait_cyc < 200) begin @(posedge i_clk); #1; wait_cyc++; end
    n_cmp++; if (b1.o_valid !== 1'b1) begin n_bad++; $display("FAIL bp_timeout: o_valid %b want 1", b1.o_valid); end
    // A competing request while the result is held must be ignored.
    b1.i_valid = 1'b1; b1.i_a = 32'd5; b1.i_b = 32'd1;
    for (int i = 0; i < 5; i++) begin
      @(posedge i_clk); #1;
      n_cmp++; if ({b1.o_valid, b1.o_ready} !== 2'b10) begin n_bad++; $display("FAIL bp_hs%0d: got %b want 10", i, {b1.o_valid, b1.o_ready}); end
      n_cmp++; if ({b1.o_quo, b1.o_rem} !== {32'd14, 32'd2}) begin n_bad++; $display("FAIL bp_data%0d: got %h %h want 0000000e 00000002", i, b1.o_quo, b1.o_rem); end
    end
    b1.i_valid = 1'b0; b1.i_ready = 1'b1;
    @(posedge i_clk); #1;
    b1.i_ready = 1'b0;
    n_cmp++; if ({b1.o_valid, b1.o_ready} !== 2'b01) begin n_bad++; $display("FAIL bp_retire: got %b want 01", {b1.o_valid, b1.o_ready}); end
    for (int i = 0; i < 40; i++) begin @(posedge i_clk); #1; if (b1.o_valid) stray++; end
    n_cmp++; if (stray !== 0) begin n_bad++; $display("FAIL bp_stray: got %0d valid cycles want 0", stray); end
  endtask

  task automatic test_reset_mid();
    logic [31:0] q, r; logic dbz, ovf; int lat;
    int stray = 0;
    b1.i_valid = 1'b1; b1.i_signed = 1'b0; b1.i_a = 32'd1000; b1.i_b = 32'd3;
    @(posedge i_clk); #1;
    b1.i_valid = 1'b0;
    repeat (10) @(posedge i_clk);
    #1;
    i_rst = 1'b1;
    @(posedge i_clk); #1;
    n_cmp++; if (b1.o_ready !== 1'b0) begin n_bad++; $display("FAIL mid_rst_ready: got %b want 0", b1.o_ready); end
    i_rst = 1'b0;
    #1;
    n_cmp++; if (b1.o_ready !== 1'b1) begin n_bad++; $display("FAIL mid_idle_ready: got %b want 1", b1.o_ready); end
    for (int i = 0; i < 50; i++) begin @(posedge i_clk); #1; if (b1.o_valid) stray++; end
    n_cmp++; if (stray !== 0) begin n_bad++; $display("FAIL mid_stray: got %0d valid cycles want 0", stray); end
    do_op(1'b0, 1'b0, 32'hFFFF_FFFF, 32'd3, q, r, dbz, ovf, lat);
    n_cmp++; if (q !== 32'h5555_5555) begin n_bad++; $display("FAIL after_rst_quo: got %h want 55555555", q); end
    n_cmp++; if (r !== 32'd0) begin n_bad++; $display("FAIL after_rst_rem: got %h want 0", r); end
  endtask

  task automatic test_steps4();
    logic [31:0] va [7] = '{32'd100, 32'hDEAD_BEEF, 32'hFFFF_FFFB, 32'd3, 32'hFFFF_FF9C, 32'd0, 32'h1234_5678};
    logic [31:0] vb [7] = '{32'd7, 32'd1, 32'hFFFF_FFFB, 32'd10, 32'd7, 32'd5, 32'd0};
    logic        vs [7] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
    logic [31:0] eq [7] = '{32'd14, 32'hDEAD_BEEF, 32'd1, 32'd0, 32'hFFFF_FFF2, 32'd0, 32'hFFFF_FFFF};
    logic [31:0] er [7] = '{32'd2, 32'd0, 32'd0, 32'd3, 32'hFFFF_FFFE, 32'd0, 32'h1234_5678};
    int          el [7] = '{10, 10, 10, 10, 10, 10, 1};
    logic [31:0] q, r; logic dbz, ovf; int lat;
    for (int i = 0; i < 7; i++) begin
      do_op(1'b1, vs[i], va[i], vb[i], q, r, dbz, ovf, lat);
      n_cmp++; if (q !== eq[i]) begin n_bad++; $display("FAIL s4_quo%0d: got %h want %h", i, q, eq[i]); end
      n_cmp++; if (r !== er[i]) begin n_bad++; $display("FAIL s4_rem%0d: got %h want %h", i, r, er[i]); end
      n_cmp++; if (lat !== el[i]) begin n_bad++; $display("FAIL s4_lat%0d: got %0d want %0d", i, lat, el[i]); end
      n_cmp++; if (dbz !== (vb[i] == 32'd0)) begin n_bad++; $display("FAIL s4_dbz%0d: got %b want %b", i, dbz, vb[i] == 32'd0); end
    end
  endtask

  initial begin
    b1.i_valid = 1'b0; b1.i_signed = 1'b0; b1.i_a = '0; b1.i_b = '0; b1.i_ready = 1'b0;
    b4.i_valid = 1'b0; b4.i_signed = 1'b0; b4.i_a = '0; b4.i_b = '0; b4.i_ready = 1'b0;
    test_reset();
    test_unsigned();
    test_signed();
    test_dbz();
    test_overflow();
    test_backpressure();
    test_reset_mid();
    test_steps4();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/div_iter.md
Name: div_iter

Overview:
- Iterative restoring divider, next generation of the single-mode divider.
- Adds signed/unsigned mode select, a configurable number of quotient bits per cycle, and valid/ready handshakes on both input and output.
- Fixed-result fast paths for divide-by-zero and signed overflow.
- Sits behind the CPU execute stage as the DIV/DIVU/REM/REMU unit; results follow RISC-V M-extension semantics.

Parameters:
- WIDTH, 32, operand/result width in bits; even, at least 4.
- STEPS, 1, quotient bits resolved per clock; power of two, divides WIDTH.

Ports:
- i_clk  in  1  clock.
- i_rst  in  1  reset.
- i_valid  in  1  request valid.
- o_ready  out  1  divider can accept a request.
- i_signed  in  1  1 = two's-complement operands, 0 = unsigned.
- i_a  in  WIDTH  dividend.
- i_b  in  WIDTH  divisor.
- o_valid  out  1  result valid, held until accepted.
- i_ready  in  1  consumer accepts result.
- o_quo  out  WIDTH  quotient.
- o_rem  out  WIDTH  remainder.
- o_dbz  out  1  result is a divide-by-zero result.
- o_ovf  out  1  result is a signed-overflow result.

Behaviour:
- Reset: i_rst, synchronous, active-high; clock i_clk.
  - While i_rst is high, all outputs are driven to 0 except o_ready, which is 0 during reset and 1 from the first cycle after reset.
  - State returns to IDLE.
  - Reset mid-operation discards the operation; no o_valid is produced.
- States: IDLE, CALC, FIX, DONE.
- IDLE:
  - o_ready=1.
  - On i_valid & o_ready, latch i_signed, both operand signs, |i_a| and |i_b| (the absolute value is taken only when i_signed; otherwise raw), then branch:
    - i_b==0 -> DONE with o_quo = all ones, o_rem = i_a, o_dbz=1.
    - i_signed & i_a==MIN & i_b==all ones -> DONE with o_quo = MIN, o_rem = 0, o_ovf=1.
    - otherwise -> CALC, counter=0, acc=0, quo=|a|.
- CALC:
  - Each cycle performs STEPS chained restoring steps: shift {acc,quo} left by 1; if acc >= divisor, subtract and set the quotient LSB.
  - acc is WIDTH+1 bits.
  - After WIDTH/STEPS cycles -> FIX.
- FIX, one cycle:
  - Negate the quotient if signed and the operand signs differ.
  - Negate the remainder if signed and the dividend is negative.
  - The quotient truncates toward zero; the remainder sign follows the dividend.
  - Register o_quo/o_rem, clear o_dbz/o_ovf -> DONE.
- DONE:
  - o_valid=1; outputs stable while o_valid & !i_ready.
  - On i_ready -> IDLE, o_valid=0 the next cycle.
  - o_ready=0 in DONE, so no same-cycle accept-and-retire.
- Latency, accept edge to o_valid high:
  - Normal path: WIDTH/STEPS + 2 cycles (32 cycles CALC + FIX + DONE entry = 34 for defaults; STEPS=4 gives 10).
  - dbz/ovf paths: 1 cycle.
- Throughput: one operation per latency+1 cycles minimum.
- i_valid while o_ready=0 is ignored. Inputs are sampled only on the accept edge and may change afterwards.
- Unsigned mode with MSB-set operands is treated as a large positive value; overflow detection is disabled.
- i_a==0 with nonzero i_b takes the normal path and yields 0/0.
- Iteration counter width: $clog2(WIDTH/STEPS)+1; no wrap before FIX.

Decomposition:
- Shared package div_pkg:
  - state encoding constants (IDLE=0, CALC=1, FIX=2, DONE=3);
  - localparam ITER = WIDTH/STEPS;
  - function neg_if(value, cond) for two's-complement conditional negate.
- Sub-module div_step:
  - combinational single restoring step, (acc, quo, divisor) -> (acc_next, quo_next);
  - instantiated STEPS times in a generate chain inside div_iter.

Test Plan:
- Unsigned, WIDTH=32, STEPS=1: a=100, b=7, i_signed=0 -> o_quo=14, o_rem=2, o_valid exactly 34 cycles after accept, o_dbz=o_ovf=0.
- Signed: a=-7 (0xFFFFFFF9), b=2 -> o_quo=-3 (0xFFFFFFFD), o_rem=-1 (0xFFFFFFFF); a=7, b=-2 -> quo=-3, rem=1.
- Divide by zero: a=0x12345678, b=0, signed and unsigned -> quo=0xFFFFFFFF, rem=0x12345678, o_dbz=1, latency 1.
- Signed overflow: a=0x80000000, b=0xFFFFFFFF, i_signed=1 -> quo=0x80000000, rem=0, o_ovf=1. Same operands with i_signed=0 -> quo=0, rem=0x80000000, normal latency.
- Backpressure and reset:
  - Hold i_ready=0 for 5 cycles in DONE -> outputs stable, o_ready=0, a new i_valid is ignored.
  - Assert i_rst at CALC cycle 10 -> next cycle IDLE, o_valid never rises.
  - A following request 0xFFFFFFFF/3 unsigned -> quo=0x55555555, rem=0.
- STEPS=4 build: random 10k signed/unsigned pairs vs reference model, latency 10, including b=1, a=b, a<b cases.
